// File: rtl/alu_ops_pkg.sv
// rtl/alu_ops_pkg.sv - operation codes, FSM states and decode helpers for alu_seq_exec
package alu_ops_pkg;

    localparam int SHAMT_W = 5;
    localparam int CNT_W   = 6;

    typedef enum logic [3:0] {
        OP_AND    = 4'b0000,
        OP_OR     = 4'b0001,
        OP_ADD_LS = 4'b0010,
        OP_XOR    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRL    = 4'b0101,
        OP_EQ     = 4'b1000,
        OP_SUB    = 4'b1010,
        OP_ADD    = 4'b1011,
        OP_NE     = 4'b1101,
        OP_LT     = 4'b1110,
        OP_GE     = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } exec_state_t;

    function automatic logic is_compare(alu_op_t op);
        return (op == OP_EQ) || (op == OP_NE) || (op == OP_LT) || (op == OP_GE);
    endfunction

    function automatic logic is_shift(alu_op_t op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// rtl/alu_iter_shifter.sv - one combinational shift step of at most SHIFT_STEP positions
module alu_iter_shifter
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  shift_right,
    input  logic [CNT_W-1:0]      remaining,
    output logic [DATA_WIDTH-1:0] next_value,
    output logic [CNT_W-1:0]      next_remaining
);

    localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(SHIFT_STEP);

    logic [CNT_W-1:0] step;

    assign step           = (remaining > STEP_MAX) ? STEP_MAX : remaining;
    assign next_value     = shift_right ? (value >> step) : (value << step);
    assign next_remaining = remaining - step;

endmodule

// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - execute-stage ALU with iterative shifts and a one-entry output buffer
module alu_seq_exec
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  BranchTaken
);

    exec_state_t state, state_next;

    alu_op_t               op_in;
    logic [SHAMT_W-1:0]    shamt;
    logic                  accept;
    logic                  load_shift;
    logic [DATA_WIDTH-1:0] calc_result;
    logic                  calc_branch;

    logic [DATA_WIDTH-1:0] acc;
    logic [CNT_W-1:0]      remaining;
    logic                  shift_right;
    logic [DATA_WIDTH-1:0] sh_next;
    logic [CNT_W-1:0]      sh_remaining;

    assign op_in      = alu_op_t'(Operation);
    assign shamt      = SrcB[SHAMT_W-1:0];
    assign in_ready   = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign out_valid  = (state == ST_HOLD);
    assign accept     = in_valid && in_ready && !flush;
    assign load_shift = accept && is_shift(op_in) && (shamt != '0);

    alu_iter_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .value          (acc),
        .shift_right    (shift_right),
        .remaining      (remaining),
        .next_value     (sh_next),
        .next_remaining (sh_remaining)
    );

    // Shift ops only reach this path with a zero amount, where the result is SrcA.
    always_comb begin
        calc_result = '0;
        calc_branch = 1'b0;
        case (op_in)
            OP_AND:    calc_result = SrcA & SrcB;
            OP_OR:     calc_result = SrcA | SrcB;
            OP_XOR:    calc_result = SrcA ^ SrcB;
            OP_ADD,
            OP_ADD_LS: calc_result = SrcA + SrcB;
            OP_SUB:    calc_result = SrcA - SrcB;
            OP_SLL,
            OP_SRL:    calc_result = SrcA;
            OP_EQ:     calc_branch = (SrcA == SrcB);
            OP_NE:     calc_branch = (SrcA != SrcB);
            OP_LT:     calc_branch = ($signed(SrcA) <  $signed(SrcB));
            OP_GE:     calc_branch = ($signed(SrcA) >= $signed(SrcB));
            default:   calc_result = '0;
        endcase
        if (is_compare(op_in)) begin
            calc_result = DATA_WIDTH'(calc_branch);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = load_shift ? ST_SHIFT : ST_HOLD;
                end
            end
            ST_SHIFT: begin
                if (sh_remaining == '0) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_next = load_shift ? ST_SHIFT : ST_HOLD;
                end else if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ALUResult is left untouched on flush; out_valid dropping is what discards it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc         <= '0;
            remaining   <= '0;
            shift_right <= 1'b0;
            ALUResult   <= '0;
            BranchTaken <= 1'b0;
        end else if (flush) begin
            remaining <= '0;
        end else if (accept) begin
            if (load_shift) begin
                acc         <= SrcA;
                remaining   <= {1'b0, shamt};
                shift_right <= (op_in == OP_SRL);
            end else begin
                ALUResult   <= calc_result;
                BranchTaken <= calc_branch;
            end
        end else if (state == ST_SHIFT) begin
            acc       <= sh_next;
            remaining <= sh_remaining;
            if (sh_remaining == '0) begin
                ALUResult   <= sh_next;
                BranchTaken <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - directed self-checking bench for alu_seq_exec
module tb_alu_seq_exec;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        BranchTaken;

    int errors = 0;
    int checks = 0;

    alu_seq_exec #(
        .DATA_WIDTH (32),
        .SHIFT_STEP (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Operation   (Operation),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALUResult   (ALUResult),
        .BranchTaken (BranchTaken)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        SrcA      = 32'hDEAD_BEEF;
        SrcB      = 32'hFFFF_FFFF;
        Operation = 4'b0100;
    endtask

    // Counts edges from accept (inclusive) until out_valid; in_ready must stay low meanwhile.
    task automatic wait_valid(output int edges, output int ready_high);
        edges      = 1;
        ready_high = 0;
        while (!out_valid && edges < 200) begin
            if (in_ready) ready_high++;
            tick();
            edges++;
        end
    endtask

    task automatic alu_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic br);
        issue(op, a, b);
        check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, " result"}, ALUResult, res);
        check({tag, " branch"}, {31'd0, BranchTaken}, {31'd0, br});
    endtask

    initial begin
        int edges;
        int ready_high;
        int seen;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Operation = 4'b0000;
        SrcA      = '0;
        SrcB      = '0;
        #12;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset result", ALUResult, 32'd0);
        check("reset branch", {31'd0, BranchTaken}, 32'd0);
        #4 reset_n = 1'b1;
        tick();

        alu_op("add", 4'b1011, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0);
        alu_op("add_ls", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0);
        alu_op("sub", 4'b1010, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
        alu_op("lt", 4'b1110, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);
        alu_op("ge", 4'b1111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        alu_op("eq", 4'b1000, 32'h1234, 32'h1234, 32'd1, 1'b1);
        alu_op("ne", 4'b1101, 32'h1234, 32'h1234, 32'd0, 1'b0);
        alu_op("or", 4'b0001, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1'b0);
        alu_op("unused", 4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
        tick();
        check("drain idle", {31'd0, out_valid}, 32'd0);

        issue(4'b0100, 32'h1, 32'd31);
        wait_valid(edges, ready_high);
        check("sll31 latency", edges, 32'd32);
        check("sll31 in_ready low", ready_high, 32'd0);
        check("sll31 result", ALUResult, 32'h8000_0000);
        tick();

        issue(4'b0101, 32'h8000_0000, 32'd4);
        wait_valid(edges, ready_high);
        check("srl4 latency", edges, 32'd5);
        check("srl4 result", ALUResult, 32'h0800_0000);
        tick();

        issue(4'b0100, 32'hCAFE_F00D, 32'hFFFF_FFE0);
        wait_valid(edges, ready_high);
        check("sll0 latency", edges, 32'd1);
        check("sll0 result", ALUResult, 32'hCAFE_F00D);
        tick();

        out_ready = 1'b0;
        issue(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00);
        for (int i = 0; i < 3; i++) begin
            check("bp valid", {31'd0, out_valid}, 32'd1);
            check("bp result", ALUResult, 32'h0FF0_0FF0);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        Operation = 4'b0001;
        SrcA      = 32'h1;
        SrcB      = 32'h2;
        in_valid  = 1'b1;
        #1;
        check("b2b in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b valid", {31'd0, out_valid}, 32'd1);
        check("b2b result", ALUResult, 32'h3);
        tick();

        issue(4'b0100, 32'h1, 32'd20);
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush shift in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("flush shift never valid", seen, 32'd0);

        out_ready = 1'b0;
        issue(4'b0000, 32'hF0, 32'h3C);
        check("hold and result", ALUResult, 32'h30);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush hold valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;

        flush     = 1'b1;
        Operation = 4'b0001;
        SrcA      = 32'h5;
        SrcB      = 32'h5;
        in_valid  = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush input dropped", {31'd0, out_valid}, 32'd0);

        issue(4'b0100, 32'h1, 32'd31);
        tick();
        tick();
        #3 reset_n = 1'b0;
        #1;
        check("async rst result", ALUResult, 32'd0);
        check("async rst valid", {31'd0, out_valid}, 32'd0);
        check("async rst branch", {31'd0, BranchTaken}, 32'd0);
        tick();
        #2 reset_n = 1'b1;
        #1;
        check("post rst in_ready", {31'd0, in_ready}, 32'd1);
        check("post rst out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        alu_op("post rst and", 4'b0000, 32'h0000_FF00, 32'h0000_0F0F, 32'h0000_0F00, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
- Execute-stage ALU that sits directly downstream of the ALU operation decoder.
- Consumes the 4-bit Operation code plus two 32-bit operands and produces a registered result and a branch-taken flag.
- Single-cycle for logic, arithmetic and compare ops; shifts run iteratively through a small FSM.
- valid/ready on both sides, one-entry output buffer, synchronous flush for pipeline squash.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- SHIFT_STEP, 1, maximum bit positions shifted per cycle; legal values 1, 2, 4, 8, 16, 32.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of any in-flight or held operation.
- in_valid  input  1  upstream offers Operation, SrcA, SrcB.
- in_ready  output  1  block can accept this cycle.
- Operation  input  4  ALU operation code from the decoder.
- SrcA  input  DATA_WIDTH  operand A (rs1 / PC).
- SrcB  input  DATA_WIDTH  operand B (rs2 / immediate); SrcB[4:0] is the shift amount.
- out_valid  output  1  ALUResult and BranchTaken are valid.
- out_ready  input  1  downstream consumes the result this cycle.
- ALUResult  output  DATA_WIDTH  registered result.
- BranchTaken  output  1  registered branch-condition result.

Behaviour:
- Operation encoding:
  - 0000 AND; 0001 OR; 0011 XOR.
  - 0010 ADD (load/store address); 1011 ADD; 1010 SUB (A−B).
  - 0100 SLL; 0101 SRL (logical, zero fill).
  - 1000 EQ; 1101 NE; 1110 LT signed; 1111 GE signed.
  - 0110, 0111, 1001, 1100 are unused: ALUResult=0, BranchTaken=0, single-cycle.
- Compare ops: BranchTaken = condition, ALUResult = {0…0, condition}. All non-compare ops drive BranchTaken=0.
- Arithmetic wraps modulo 2^DATA_WIDTH; no carry or overflow output.
- FSM states:
  - IDLE: no data held.
  - SHIFT: shift in progress.
  - HOLD: result held, out_valid=1.
- Transfers:
  - Input transfer = in_valid && in_ready at a rising edge.
  - Output transfer = out_valid && out_ready at a rising edge.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is 0 in SHIFT and combinational from state and out_ready.
- Non-shift op accepted at edge N: result registered at N; out_valid=1 from N to N+1; state→HOLD.
- Shift op accepted at edge N with k = SrcB[4:0]:
  - k=0: result = SrcA; HOLD after N.
  - k>0: SrcA and k are loaded at N, state→SHIFT. Each later edge shifts by min(SHIFT_STEP, remaining) and decrements remaining.
  - When remaining reaches 0, the final value is written and state→HOLD at that edge.
  - Total latency is 1 + ceil(k/SHIFT_STEP) edges.
- HOLD:
  - ALUResult and BranchTaken are stable while out_ready=0.
  - On out_ready=1 with a simultaneous input transfer, load the new op (back-to-back, no bubble). Otherwise go to IDLE.
- out_valid=0 in IDLE and SHIFT.
- flush=1 at an edge:
  - state→IDLE, out_valid→0; any held result or partial shift is discarded.
  - No input transfer happens that edge, even if in_valid && in_ready.
  - flush has priority over everything except reset.
- Reset (reset_n low, asynchronous):
  - state=IDLE, out_valid=0, ALUResult=0, BranchTaken=0, shift counter=0.
  - Reset mid-SHIFT or mid-HOLD discards the operation.
  - No transfer is recognised while reset_n=0.
- Operands are sampled only at the input transfer edge; later changes on SrcA, SrcB or Operation have no effect.

Decomposition:
- Package alu_ops_pkg holds:
  - 4-bit enum typedef alu_op_t with the codes above.
  - FSM state typedef (IDLE/SHIFT/HOLD).
  - Helper function is_compare(alu_op_t).
- Sub-module alu_iter_shifter: combinational one-step shifter taking value, direction and remaining count, and returning the next value and next remaining count (at most SHIFT_STEP per step). The FSM and registers stay in alu_seq_exec.

Test Plan:
- ADD: Operation=1011, A=0x7FFFFFFF, B=1, out_ready=1 → out_valid one edge after accept, ALUResult=0x80000000, BranchTaken=0; 0010 gives the same result.
- SUB and compares:
  - 1010, A=5, B=7 → 0xFFFFFFFE.
  - 1110, A=0xFFFFFFFF, B=1 → BranchTaken=1, ALUResult=1.
  - 1111 same operands → 0.
  - 1000 A=B=0x1234 → 1.
  - 1101 same operands → 0.
- SLL, SHIFT_STEP=1: A=0x1, B=31 → in_ready=0 for 31 cycles, out_valid after 32 edges, ALUResult=0x80000000. SRL A=0x80000000, B=4 → 0x08000000 after 5 edges. B=0 → A after 1 edge.
- Backpressure: hold out_ready=0 for 3 cycles after an XOR (A=0xF0F0F0F0, B=0xFF00FF00) → result 0x0FF00FF0 stable and out_valid=1 throughout. Then out_ready=1 with a new in_valid → both transfers on the same edge, next result one edge later.
- flush during SHIFT (SLL B=20, flush at cycle 5) → out_valid never rises for that op, in_ready=1 next cycle. flush in HOLD drops the result. flush with simultaneous in_valid → op not accepted.
- Async reset asserted mid-SHIFT, between clock edges → outputs zero immediately. After release, in_ready=1, out_valid=0, and the first new AND op returns the correct result.
